xtea_accel: RTL and testbench
=============================

# xtea_accel

Memory-mapped XTEA block-cipher accelerator sitting directly downstream of the core-sharing lock. It consumes the lock's granted-core bus (address, write enable, select, write data) and returns read data to it. It holds a 128-bit key and a 64-bit data block in registers and encrypts or decrypts that block in place, one full XTEA round per clock.

## Interface
- `BASE_ADDR`, default 32'd40: byte address of KEY0. All registers are word-spaced and sit below the lock's own address (84).
- `ROUNDS`, default 32: number of XTEA rounds, 1..32.
- `DELTA`, default 32'h9E3779B9: XTEA round constant.
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous active-high reset.
- `addr_i`, in, 32: byte address from the lock.
- `wr_en_i`, in, 1: write strobe, qualified by `select_i`.
- `select_i`, in, 1: accelerator selected.
- `data_i`, in, 32: write data.
- `data_o`, out, 32: read data to the lock. Combinational.
- `busy_o`, out, 1: computation in progress.
- `done_o`, out, 1: one-cycle completion pulse.

## Operation
- Register map, as an offset from `BASE_ADDR`:
  - +0/+4/+8/+12: KEY0..KEY3, R/W.
  - +16: DATA0 (v0), R/W.
  - +20: DATA1 (v1), R/W.
  - +24: CTRL, write-only, reads 0. bit0 = start, bit1 = mode (0 encrypt, 1 decrypt).
  - +28: STATUS, read-only. bit0 = busy, bit1 = done, bit2 = err.
- Addresses outside the map, or `select_i`=0, give `data_o`=0. Writes to them are ignored.
- A write takes effect only when `select_i & wr_en_i`.
- FSM states are IDLE and RUN.
- IDLE -> RUN on a CTRL write with bit0=1. On that transition:
  - round counter = 0; done and err cleared.
  - encrypt: sum = 0.
  - decrypt: sum = DELTA*ROUNDS mod 2^32 (0xC6EF3720 at 32 rounds).
- Each RUN cycle performs one round, all arithmetic mod 2^32:
  - encrypt: v0 += (((v1<<4)^(v1>>5))+v1) ^ (sum+KEY[sum[1:0]]); sum += DELTA; v1 += (((v0'<<4)^(v0'>>5))+v0') ^ (sum'+KEY[sum'[12:11]]).
  - decrypt: v1 -= (((v0<<4)^(v0>>5))+v0) ^ (sum+KEY[sum[12:11]]); sum -= DELTA; v0 -= (((v1'<<4)^(v1'>>5))+v1') ^ (sum'+KEY[sum'[1:0]]).
  - v0', v1' and sum' are the values updated earlier in the same round.
- RUN -> IDLE on the edge that completes round ROUNDS-1. That same edge sets done and drives `done_o`=1 for exactly the following cycle.
- While busy:
  - writes to KEY/DATA are ignored and set err.
  - a CTRL start is ignored and sets err.
  - reads return live intermediate values.
- done stays set until the next accepted start or reset.

## Timing
- Reset values: all registers 0, state IDLE, `busy_o`=0, `done_o`=0. `data_o` is 0 unless a mapped register is read.
- A start write sampled at edge T puts `busy_o` high from T until edge T+ROUNDS.
- Rounds execute on edges T+1..T+ROUNDS. The result is readable, busy=0 and done=1 after edge T+ROUNDS.
- `done_o` is high during the cycle after edge T+ROUNDS.
- Reads are combinational with zero latency. A register write is visible on reads the cycle after its edge.
- Reset asserted mid-RUN aborts immediately; all registers return to 0.
- Start written on the same edge as completion: the completion edge returns to IDLE and the start is ignored with err set. Software polls STATUS before issuing the next start.

## Configuration
- `XTEA_DECRYPT_EN` defined: CTRL bit1 selects decrypt as specified above.
- `XTEA_DECRYPT_EN` undefined:
  - decrypt datapath and DELTA*ROUNDS init not built.
  - CTRL bit1 ignored; every start encrypts.

## Test plan
- Reset, then read all 8 registers -> all return 0; `busy_o`=0, `done_o`=0.
- Keys 0, DATA0=DATA1=0, write CTRL=1 -> busy for 32 cycles, `done_o` pulse, then DATA0=0xDEE9D4D8, DATA1=0xF7131ED9, STATUS=0x2.
- From that ciphertext, write CTRL=3 (with `XTEA_DECRYPT_EN`) -> DATA0=DATA1=0 after 32 cycles.
- Write DATA0=0x12345678 while busy -> write ignored, final result unchanged versus an undisturbed run, STATUS=0x6.
- Assert `rst` at round 10 -> all registers 0 and busy=0 immediately; a new start computes correctly.
- Write with `select_i`=0, and read at BASE_ADDR+32 -> no register changes; `data_o`=0.

Source files
------------

// File: rtl/xtea_accel.sv
// rtl/xtea_accel.sv - memory-mapped XTEA block-cipher accelerator, one round per clock
//
// Optional feature macro: XTEA_DECRYPT_EN (builds the decrypt datapath; CTRL bit1 selects it).
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   addr_i     byte address from the lock
//   wr_en_i    write strobe, qualified by select_i
//   select_i   accelerator selected
//   data_i     write data
//   data_o     combinational read data (0 when unselected or unmapped)
//   busy_o     computation in progress
//   done_o     one-cycle completion pulse
//
// Register map (offset from BASE_ADDR):
//   +0..+12 KEY0..KEY3, +16 DATA0 (v0), +20 DATA1 (v1),
//   +24 CTRL (wo: bit0 start, bit1 mode), +28 STATUS (ro: bit0 busy, bit1 done, bit2 err)
module xtea_accel #(
    parameter logic [31:0] BASE_ADDR = 32'd40,
    parameter int          ROUNDS    = 32,
    parameter logic [31:0] DELTA     = 32'h9E3779B9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic        wr_en_i,
    input  logic        select_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_key [4];
    logic [31:0] r_v0;
    logic [31:0] r_v1;
    logic [31:0] r_sum;
    logic [4:0]  r_cnt;
    logic        r_done;
    logic        r_err;
    logic        r_done_pulse;

    logic [31:0] w_off;
    logic        w_hit;
    logic [2:0]  w_idx;
    logic        w_wr;
    logic        w_busy;
    logic        w_last;
    logic        w_start;

    logic [31:0] w_e_v0;
    logic [31:0] w_e_sum;
    logic [31:0] w_e_v1;
    logic [31:0] w_n_v0;
    logic [31:0] w_n_v1;
    logic [31:0] w_n_sum;

    function automatic logic [31:0] mix(input logic [31:0] x);
        return ((x << 4) ^ (x >> 5)) + x;
    endfunction

    // Offset decode; unaligned or out-of-window addresses fall outside the map.
    assign w_off   = addr_i - BASE_ADDR;
    assign w_hit   = select_i && (w_off < 32'd32) && (w_off[1:0] == 2'b00);
    assign w_idx   = w_off[4:2];
    assign w_wr    = w_hit && wr_en_i;
    assign w_busy  = (r_state == S_RUN);
    assign w_last  = (r_cnt == 5'(ROUNDS - 1));
    assign w_start = w_wr && (w_idx == 3'd6) && data_i[0];

    // Encrypt round: the v1 half uses the v0 and sum values already updated this round.
    assign w_e_v0  = r_v0 + (mix(r_v1) ^ (r_sum + r_key[r_sum[1:0]]));
    assign w_e_sum = r_sum + DELTA;
    assign w_e_v1  = r_v1 + (mix(w_e_v0) ^ (w_e_sum + r_key[w_e_sum[12:11]]));

`ifdef XTEA_DECRYPT_EN
    localparam logic [31:0] DEC_SUM_INIT = 32'(DELTA * ROUNDS);

    logic        r_mode;
    logic [31:0] w_d_v1;
    logic [31:0] w_d_sum;
    logic [31:0] w_d_v0;

    // Decrypt round: exact inverse of the encrypt round, halves processed in reverse order.
    assign w_d_v1  = r_v1 - (mix(r_v0) ^ (r_sum + r_key[r_sum[12:11]]));
    assign w_d_sum = r_sum - DELTA;
    assign w_d_v0  = r_v0 - (mix(w_d_v1) ^ (w_d_sum + r_key[w_d_sum[1:0]]));

    assign w_n_v0  = r_mode ? w_d_v0  : w_e_v0;
    assign w_n_v1  = r_mode ? w_d_v1  : w_e_v1;
    assign w_n_sum = r_mode ? w_d_sum : w_e_sum;
`else
    assign w_n_v0  = w_e_v0;
    assign w_n_v1  = w_e_v1;
    assign w_n_sum = w_e_sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_RUN;
            S_RUN:   if (w_last)  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_key[i] <= '0;
            r_v0         <= '0;
            r_v1         <= '0;
            r_sum        <= '0;
            r_cnt        <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_done_pulse <= 1'b0;
`ifdef XTEA_DECRYPT_EN
            r_mode       <= 1'b0;
`endif
        end else begin
            r_done_pulse <= 1'b0;
            if (w_busy) begin
                r_v0  <= w_n_v0;
                r_v1  <= w_n_v1;
                r_sum <= w_n_sum;
                r_cnt <= r_cnt + 5'd1;
                if (w_last) begin
                    r_done       <= 1'b1;
                    r_done_pulse <= 1'b1;
                end
                // Operand writes or a start while busy are dropped and flagged;
                // this also covers a start landing on the completion edge.
                if (w_wr && ((w_idx <= 3'd5) || (w_idx == 3'd6 && data_i[0]))) begin
                    r_err <= 1'b1;
                end
            end else begin
                if (w_wr) begin
                    case (w_idx)
                        3'd0, 3'd1, 3'd2, 3'd3: r_key[w_idx[1:0]] <= data_i;
                        3'd4:                   r_v0 <= data_i;
                        3'd5:                   r_v1 <= data_i;
                        default:                ;
                    endcase
                end
                if (w_start) begin
                    r_cnt  <= '0;
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
`ifdef XTEA_DECRYPT_EN
                    r_mode <= data_i[1];
                    r_sum  <= data_i[1] ? DEC_SUM_INIT : 32'd0;
`else
                    r_sum  <= 32'd0;
`endif
                end
            end
        end
    end

    always_comb begin
        data_o = '0;
        if (w_hit) begin
            case (w_idx)
                3'd0, 3'd1, 3'd2, 3'd3: data_o = r_key[w_idx[1:0]];
                3'd4:    data_o = r_v0;
                3'd5:    data_o = r_v1;
                3'd7:    data_o = {29'd0, r_err, r_done, w_busy};
                default: data_o = '0;
            endcase
        end
    end

    assign busy_o = w_busy;
    assign done_o = r_done_pulse;

endmodule

// File: tb/tb_xtea_accel.sv
// tb/tb_xtea_accel.sv - self-checking bench for xtea_accel with a result scoreboard
module tb_xtea_accel;

    localparam logic [31:0] BASE  = 32'd40;
    localparam logic [31:0] DELTA = 32'h9E3779B9;
    localparam logic [31:0] O_K0 = 0, O_K1 = 4, O_K2 = 8, O_K3 = 12;
    localparam logic [31:0] O_D0 = 16, O_D1 = 20, O_CTRL = 24, O_STAT = 28;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr_i = '0;
    logic        wr_en_i = 1'b0;
    logic        select_i = 1'b0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        busy_o;
    logic        done_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb_q[$];

    xtea_accel dut (
        .clk      (clk),
        .rst      (rst),
        .addr_i   (addr_i),
        .wr_en_i  (wr_en_i),
        .select_i (select_i),
        .data_i   (data_i),
        .data_o   (data_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #10 clk = ~clk;

    function automatic logic [31:0] kw(input logic [127:0] k, input logic [1:0] i);
        return k[{i, 5'd0} +: 32];
    endfunction

    // Reference XTEA encipher, n rounds, key word i at k[32*i +: 32].
    function automatic logic [63:0] ref_enc(input logic [127:0] k, input logic [31:0] a,
                                            input logic [31:0] b, input int n);
        logic [31:0] s = 32'd0;
        for (int i = 0; i < n; i++) begin
            a = a + ((((b << 4) ^ (b >> 5)) + b) ^ (s + kw(k, s[1:0])));
            s = s + DELTA;
            b = b + ((((a << 4) ^ (a >> 5)) + a) ^ (s + kw(k, s[12:11])));
        end
        return {a, b};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_sb(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            exp = 32'hxxxx_xxxx;
        end else begin
            exp = sb_q.pop_front();
        end
        check(tag, obs, exp);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic sel);
        addr_i   = BASE + off;
        data_i   = d;
        wr_en_i  = 1'b1;
        select_i = sel;
        @(posedge clk);
        #1;
        wr_en_i  = 1'b0;
        select_i = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] d);
        addr_i   = addr;
        wr_en_i  = 1'b0;
        select_i = 1'b1;
        #1;
        d = data_o;
        select_i = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy_o && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic load(input logic [127:0] k, input logic [31:0] a, input logic [31:0] b);
        wr(O_K0, k[31:0], 1'b1);
        wr(O_K1, k[63:32], 1'b1);
        wr(O_K2, k[95:64], 1'b1);
        wr(O_K3, k[127:96], 1'b1);
        wr(O_D0, a, 1'b1);
        wr(O_D1, b, 1'b1);
    endtask

    initial begin
        logic [31:0]  r;
        logic [63:0]  m;
        logic [127:0] k2;
        int           cyc;

        k2 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd(BASE + 32'(i * 4), r);
            check($sformatf("rst_reg%0d", i), r, 32'd0);
        end

        // Zero key / zero data encrypt: known-answer ciphertext
        sb_q.push_back(32'hDEE9D4D8);
        sb_q.push_back(32'hF7131ED9);
        wr(O_CTRL, 32'd1, 1'b1);
        check("kat_busy_start", {31'd0, busy_o}, 32'd1);
        wait_idle(cyc);
        check("kat_cycles", 32'(cyc), 32'd32);
        check("kat_done_pulse", {31'd0, done_o}, 32'd1);
        rd(BASE + O_D0, r); check_sb("kat_d0", r);
        rd(BASE + O_D1, r); check_sb("kat_d1", r);
        rd(BASE + O_STAT, r); check("kat_status", r, 32'h2);
        rd(BASE + O_CTRL, r); check("ctrl_reads0", r, 32'd0);
        @(posedge clk); #1;
        check("kat_done_drop", {31'd0, done_o}, 32'd0);

        // Mode bit: decrypt back to zero, or re-encrypt when decrypt is not built
`ifdef XTEA_DECRYPT_EN
        m = 64'd0;
`else
        m = ref_enc(128'd0, 32'hDEE9D4D8, 32'hF7131ED9, 32);
`endif
        sb_q.push_back(m[63:32]);
        sb_q.push_back(m[31:0]);
        wr(O_CTRL, 32'd3, 1'b1);
        wait_idle(cyc);
        check("mode_cycles", 32'(cyc), 32'd32);
        rd(BASE + O_D0, r); check_sb("mode_d0", r);
        rd(BASE + O_D1, r); check_sb("mode_d1", r);

        // Nonzero key, live readback mid-run, ignored write while busy sets err
        load(k2, 32'h01234567, 32'h89ABCDEF);
        m = ref_enc(k2, 32'h01234567, 32'h89ABCDEF, 3);
        sb_q.push_back(m[63:32]);
        m = ref_enc(k2, 32'h01234567, 32'h89ABCDEF, 32);
        sb_q.push_back(m[63:32]);
        sb_q.push_back(m[31:0]);
        wr(O_CTRL, 32'd1, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        rd(BASE + O_D0, r); check_sb("live_d0_r3", r);
        wr(O_D0, 32'h12345678, 1'b1);
        rd(BASE + O_STAT, r); check("busy_status", r, 32'h5);
        wait_idle(cyc);
        rd(BASE + O_D0, r); check_sb("err_d0", r);
        rd(BASE + O_D1, r); check_sb("err_d1", r);
        rd(BASE + O_STAT, r); check("err_status", r, 32'h6);

        // Reset at round 10 aborts, then a fresh start computes correctly
        wr(O_CTRL, 32'd1, 1'b1);
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd(BASE + 32'(i * 4), r);
            check($sformatf("abort_reg%0d", i), r, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        load(k2, 32'hCAFEF00D, 32'h55AA33CC);
        m = ref_enc(k2, 32'hCAFEF00D, 32'h55AA33CC, 32);
        sb_q.push_back(m[63:32]);
        sb_q.push_back(m[31:0]);
        wr(O_CTRL, 32'd1, 1'b1);
        wait_idle(cyc);
        check("restart_cycles", 32'(cyc), 32'd32);
        rd(BASE + O_D0, r); check_sb("restart_d0", r);
        rd(BASE + O_D1, r); check_sb("restart_d1", r);
        rd(BASE + O_STAT, r); check("restart_status", r, 32'h2);

        // Unselected write ignored; unmapped and unselected reads give 0
        sb_q.push_back(m[63:32]);
        wr(O_D0, 32'hA5A5A5A5, 1'b0);
        rd(BASE + O_D0, r); check_sb("nosel_d0", r);
        rd(BASE + 32'd32, r); check("unmapped_rd", r, 32'd0);
        addr_i = BASE + O_D0; select_i = 1'b0; #1;
        check("nosel_rd", data_o, 32'd0);

        // Start landing on the completion edge is ignored with err
        wr(O_CTRL, 32'd1, 1'b1);
        repeat (31) begin @(posedge clk); #1; end
        wr(O_CTRL, 32'd1, 1'b1);
        check("edge_busy", {31'd0, busy_o}, 32'd0);
        check("edge_done_pulse", {31'd0, done_o}, 32'd1);
        rd(BASE + O_STAT, r); check("edge_status", r, 32'h6);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
